// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, folds E0/F0
// prefixes into key events and buffers them in a show-ahead FIFO.
module ps2_key_event_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             evt_ready,
  input  logic             clr_err,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow,
  output logic             frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_s;

  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          frame_rdy_q, frame_rdy_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [7:0] byte_s;
  logic       frame_ok_s, good_s, bad_s;
  logic       is_e0_s, is_f0_s;
  logic       ext_s, brk_s, emit_s;
  logic [9:0] evt_word_s;
  logic [8:0] key_s;

  dec_state_e       state_q;
  logic [8:0]       held_key_q;
  logic             key_held_q;
  logic [CNT_W-1:0] press_q;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          valid_s, full_s, pop_s, push_ok_s, drop_s;
  logic [9:0]    head_s;

  logic overflow_q, frame_err_q;

  // Synchronisers idle high so reset release never fakes a falling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

  // Bit capture, frame completion and inactivity timeout
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_rdy_d = 1'b0;
    to_cnt_d    = to_cnt_q;
    if (fall_s) begin
      shift_d  = {data_sync_q[SYNC_STAGES-1], shift_q[10:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d   = 4'd0;
        frame_rdy_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q >= TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q     <= 11'h000;
      bit_cnt_q   <= 4'd0;
      frame_rdy_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_rdy_q <= frame_rdy_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Frame layout after 11 shifts: [0] start, [8:1] data, [9] parity, [10] stop
  assign byte_s     = shift_q[8:1];
  assign frame_ok_s = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign good_s     = frame_rdy_q & frame_ok_s;
  assign bad_s      = frame_rdy_q & ~frame_ok_s;
  assign is_e0_s    = (byte_s == 8'hE0);
  assign is_f0_s    = (byte_s == 8'hF0);
  assign ext_s      = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign brk_s      = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  // F0 is always a prefix; E0 is a prefix only before any F0 has been seen
  assign emit_s     = good_s & ~is_f0_s & ~(is_e0_s & ~brk_s);
  assign evt_word_s = {ext_s, brk_s, byte_s};
  assign key_s      = {ext_s, byte_s};

  // Prefix decoder
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else if (bad_s || emit_s) begin
      state_q <= ST_IDLE;
    end else if (good_s) begin
      case (state_q)
        ST_IDLE:    state_q <= is_f0_s ? ST_BRK : ST_EXT;
        ST_EXT:     state_q <= is_f0_s ? ST_EXT_BRK : ST_EXT;
        ST_BRK:     state_q <= ST_BRK;
        ST_EXT_BRK: state_q <= ST_EXT_BRK;
        default:    state_q <= ST_IDLE;
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  // Held-key tracking and repeat-filtered press counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_key_q <= 9'h000;
      key_held_q <= 1'b0;
      press_q    <= '0;
    end else if (emit_s && !brk_s) begin
      held_key_q <= key_s;
      key_held_q <= 1'b1;
      if (!key_held_q || (held_key_q != key_s)) begin
        press_q <= press_q + CNT_W'(1);
      end else begin
        press_q <= press_q;
      end
    end else if (emit_s && (held_key_q == key_s)) begin
      key_held_q <= 1'b0;
    end else begin
      key_held_q <= key_held_q;
    end
  end

  assign valid_s   = (cnt_q != CW'(0));
  assign full_s    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_s     = valid_s & evt_ready;
  assign push_ok_s = emit_s & (~full_s | pop_s);
  assign drop_s    = emit_s & full_s & ~pop_s;
  assign head_s    = mem_q[rd_ptr_q];

  // Event storage (contents are don't-care while the slot is empty)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= evt_word_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bad_s) begin
        frame_err_q <= 1'b1;
      end else if (clr_err) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign evt_valid   = valid_s;
  assign evt_code    = valid_s ? head_s[7:0] : 8'h00;
  assign evt_brk     = valid_s & head_s[8];
  assign evt_ext     = valid_s & head_s[9];
  assign key_held    = key_held_q;
  assign press_count = press_q;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;

endmodule
